// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and limits for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWNER_CORE = 1'b0,
        OWNER_DBG  = 1'b1
    } owner_t;

    localparam int MAX_WAIT_STATES = 15;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between the core and the debug port,
// one latched transaction at a time with configurable wait states and a one-cycle ready pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_ready,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);

    if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT_STATES) begin : g_ws_check
        $error("mem_port_arbiter: WAIT_STATES must be within 0..15");
    end

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              grant_dbg;

    // On a tie the requester that was not served last wins.
    assign grant_dbg = dbg_req && (!core_req || owner_q == OWNER_CORE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWNER_DBG;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_rdata_q <= core_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        core_rdata_d = core_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        case (state_q)
            IDLE: begin
                if (core_req || dbg_req) begin
                    state_d = ACCESS;
                    owner_d = grant_dbg ? OWNER_DBG : OWNER_CORE;
                    we_d    = grant_dbg ? dbg_we : core_we;
                    addr_d  = grant_dbg ? dbg_addr : core_addr;
                    wdata_d = grant_dbg ? dbg_wdata : core_wdata;
                end
            end
            ACCESS: begin
                state_d = (WAIT_STATES > 0) ? WAIT : DONE;
                cnt_d   = WAIT_LOAD;
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = DONE;
                else cnt_d = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
        // DONE is only ever entered from ACCESS or WAIT, so this fires once per read.
        if (state_d == DONE && !we_q) begin
            core_rdata_d = (owner_q == OWNER_CORE) ? mem_rdata : core_rdata_q;
            dbg_rdata_d  = (owner_q == OWNER_DBG) ? mem_rdata : dbg_rdata_q;
        end
    end

    assign mem_en     = state_q == ACCESS;
    assign mem_we     = mem_en && we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign core_rdata = core_rdata_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign core_ready = state_q == DONE && owner_q == OWNER_CORE;
    assign dbg_ready  = state_q == DONE && owner_q == OWNER_DBG;
    assign owner      = owner_q;

endmodule
